// File: rtl/fft_butterfly_sequencer_if.sv
// Bundles the sequencer's start/done control, RAM/ROM issue side and
// butterfly return side. master = sequencer, slave = surrounding datapath.
interface fft_butterfly_sequencer_if #(
  parameter int FFT_N = 10
);
  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [FFT_N-1:0] rd_addr_a;
  logic [FFT_N-1:0] rd_addr_b;
  logic [FFT_N-2:0] tw_addr;
  logic             bf_iact;
  logic [1:0]       bf_ictrl;
  logic [FFT_N-2:0] bf_addr;
  logic             bf_oact;
  logic [1:0]       bf_octrl;
  logic [FFT_N-2:0] bf_out_addr;
  logic             wr_en;
  logic [FFT_N-1:0] wr_addr_a;
  logic [FFT_N-1:0] wr_addr_b;

  modport master (
    input  start, bf_oact, bf_octrl, bf_out_addr,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_iact, bf_ictrl, bf_addr, wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, bf_oact, bf_octrl, bf_out_addr,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_iact, bf_ictrl, bf_addr, wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_butterfly_sequencer.sv
// In-place radix-2 DIF FFT sequencer: issues one butterfly per cycle per
// stage, waits for all results of a stage to be written back before the
// next stage reads, and maps returned butterfly indices to write addresses.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | issuing butterflies j = 1..max of the current stage
// DRAIN  | all issued, waiting for outstanding write-backs
// DONE   | one-cycle done pulse, then back to IDLE
module fft_butterfly_sequencer #(
  parameter int FFT_N = 10
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  fft_butterfly_sequencer_if.master  io_seq
);
  localparam int JW = FFT_N - 1;
  localparam int SW = (FFT_N > 1) ? $clog2(FFT_N) : 1;
  localparam logic [JW-1:0] J_MAX  = '1;
  localparam logic [SW-1:0] S_LAST = SW'(FFT_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  // Distance between the A and B elements of a butterfly in stage s.
  function automatic logic [FFT_N-1:0] f_span(input logic [SW-1:0] s);
    return FFT_N'(1) << (JW - int'(s));
  endfunction

  // A address = j with a zero bit inserted at the span position.
  function automatic logic [FFT_N-1:0] f_addr_a(input logic [JW-1:0] j,
                                                input logic [SW-1:0] s);
    logic [FFT_N-1:0] jx;
    logic [FFT_N-1:0] mask;
    jx   = {1'b0, j};
    mask = f_span(s) - FFT_N'(1);
    return ((jx & ~mask) << 1) | (jx & mask);
  endfunction

  function automatic logic [JW-1:0] f_tw(input logic [JW-1:0] j,
                                         input logic [SW-1:0] s);
    logic [FFT_N-1:0] k;
    k = {1'b0, j} & (f_span(s) - FFT_N'(1));
    k = k << s;
    return k[JW-1:0];
  endfunction

  state_t           r_state;
  logic [SW-1:0]    r_stage;
  logic [JW-1:0]    r_j;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;
  logic [FFT_N-1:0] r_rd_addr_a;
  logic [FFT_N-1:0] r_rd_addr_b;
  logic [JW-1:0]    r_tw_addr;
  logic [JW-1:0]    r_rd_j;
  logic [1:0]       r_rd_ctrl;
  logic             r_iact;
  logic [1:0]       r_ictrl;
  logic [JW-1:0]    r_bf_addr;
  logic             r_wr_en;
  logic [FFT_N-1:0] r_wr_addr_a;
  logic [FFT_N-1:0] r_wr_addr_b;
  logic [FFT_N:0]   r_cnt;

  logic             w_issue;
  logic [JW-1:0]    w_iss_j;
  logic [SW-1:0]    w_iss_s;
  logic [FFT_N-1:0] w_iss_a;
  logic [1:0]       w_iss_ctrl;
  logic             w_empty;
  logic             w_last_wr;
  logic [FFT_N-1:0] w_wr_a;
  logic             w_unused_octrl;

  assign w_unused_octrl = ^io_seq.bf_octrl;

  // Pipeline holds nothing in flight: no read pending, no issue pending, no results owed.
  assign w_empty   = !r_rd_en && !r_iact && (r_cnt == '0);
  // This cycle's write retires the last outstanding butterfly.
  assign w_last_wr = r_wr_en && (r_cnt == (FFT_N+1)'(1)) && !r_rd_en && !r_iact;

  // Select which butterfly (if any) is read this cycle; stage starts issue j=0 immediately.
  always_comb begin
    w_issue = 1'b0;
    w_iss_j = r_j;
    w_iss_s = r_stage;
    case (r_state)
      S_IDLE: begin
        w_issue = io_seq.start;
        w_iss_j = '0;
        w_iss_s = '0;
      end
      S_ISSUE: w_issue = 1'b1;
      S_DRAIN: begin
        w_issue = w_empty && (r_stage != S_LAST);
        w_iss_j = '0;
        w_iss_s = r_stage + SW'(1);
      end
      default: w_issue = 1'b0;
    endcase
    w_iss_a    = f_addr_a(w_iss_j, w_iss_s);
    w_iss_ctrl = {(w_iss_j == J_MAX) && (w_iss_s == S_LAST), (w_iss_j == '0)};
  end

  // Control FSM plus read issue and the one-cycle delayed butterfly issue.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_stage     <= '0;
      r_j         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw_addr   <= '0;
      r_rd_j      <= '0;
      r_rd_ctrl   <= '0;
      r_iact      <= 1'b0;
      r_ictrl     <= '0;
      r_bf_addr   <= '0;
    end else begin
      r_rd_en   <= 1'b0;
      r_done    <= 1'b0;
      r_iact    <= r_rd_en;
      r_bf_addr <= r_rd_j;
      r_ictrl   <= r_rd_en ? r_rd_ctrl : 2'b00;
      if (w_issue) begin
        r_rd_en     <= 1'b1;
        r_rd_addr_a <= w_iss_a;
        r_rd_addr_b <= w_iss_a | f_span(w_iss_s);
        r_tw_addr   <= f_tw(w_iss_j, w_iss_s);
        r_rd_j      <= w_iss_j;
        r_rd_ctrl   <= w_iss_ctrl;
        r_j         <= w_iss_j + JW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (io_seq.start) begin
            r_busy  <= 1'b1;
            r_stage <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_j == J_MAX) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_last_wr && (r_stage == S_LAST)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else if (w_empty && (r_stage != S_LAST)) begin
            r_stage <= r_stage + SW'(1);
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_wr_a = f_addr_a(io_seq.bf_out_addr, r_stage);

  // Write-back of returned results and count of butterflies still owed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_en     <= 1'b0;
      r_wr_addr_a <= '0;
      r_wr_addr_b <= '0;
      r_cnt       <= '0;
    end else begin
      r_wr_en     <= io_seq.bf_oact && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
      r_wr_addr_a <= w_wr_a;
      r_wr_addr_b <= w_wr_a | f_span(r_stage);
      case ({r_iact, r_wr_en})
        2'b10:   r_cnt <= r_cnt + (FFT_N+1)'(1);
        2'b01:   if (r_cnt != '0) r_cnt <= r_cnt - (FFT_N+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
                                   !(r_wr_en && (r_cnt == '0)));

  assign io_seq.busy      = r_busy;
  assign io_seq.done      = r_done;
  assign io_seq.rd_en     = r_rd_en;
  assign io_seq.rd_addr_a = r_rd_addr_a;
  assign io_seq.rd_addr_b = r_rd_addr_b;
  assign io_seq.tw_addr   = r_tw_addr;
  assign io_seq.bf_iact   = r_iact;
  assign io_seq.bf_ictrl  = r_ictrl;
  assign io_seq.bf_addr   = r_bf_addr;
  assign io_seq.wr_en     = r_wr_en;
  assign io_seq.wr_addr_a = r_wr_addr_a;
  assign io_seq.wr_addr_b = r_wr_addr_b;
endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Bench for fft_butterfly_sequencer: an 8-point instance checked against a
// hand-computed address table, and a 1024-point instance checked for totals
// and stage-0 / stage-9 address properties. Both use a 6-cycle butterfly.
module tb_fft_butterfly_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_butterfly_sequencer_if #(.FFT_N(3))  sif ();
  fft_butterfly_sequencer_if #(.FFT_N(10)) bif ();

  fft_butterfly_sequencer #(.FFT_N(3)) dut_s (
    .i_clk(clk), .i_reset(rst), .io_seq(sif.master));
  fft_butterfly_sequencer #(.FFT_N(10)) dut_b (
    .i_clk(clk), .i_reset(rst), .io_seq(bif.master));

  // 6-cycle butterfly models
  logic [5:0] s_v = '0;
  logic [1:0] s_c [6];
  logic [1:0] s_a [6];
  logic [5:0] b_v = '0;
  logic [1:0] b_c [6];
  logic [8:0] b_a [6];
  always @(posedge clk) begin
    s_v <= {s_v[4:0], sif.bf_iact};
    b_v <= {b_v[4:0], bif.bf_iact};
    s_c[0] <= sif.bf_ictrl; s_a[0] <= sif.bf_addr;
    b_c[0] <= bif.bf_ictrl; b_a[0] <= bif.bf_addr;
    for (int i = 1; i < 6; i++) begin
      s_c[i] <= s_c[i-1]; s_a[i] <= s_a[i-1];
      b_c[i] <= b_c[i-1]; b_a[i] <= b_a[i-1];
    end
  end
  assign sif.bf_oact = s_v[5];
  assign sif.bf_octrl = s_c[5];
  assign sif.bf_out_addr = s_a[5];
  assign bif.bf_oact = b_v[5];
  assign bif.bf_octrl = b_c[5];
  assign bif.bf_out_addr = b_a[5];

  // Event logs for the 8-point instance, sampled on the falling edge
  int cyc = 0;
  int n_rd = 0, n_ia = 0, n_wr = 0, n_dn = 0;
  int rd_cyc [256]; int rd_a [256]; int rd_b [256]; int rd_tw [256]; int rd_busy [256];
  int ia_cyc [256]; int ia_addr [256]; int ia_ctrl [256];
  int wr_cyc [256]; int wr_a [256]; int wr_b [256];
  int dn_cyc [16];  int dn_busy [16];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sif.rd_en && n_rd < 256) begin
      rd_cyc[n_rd] = cyc; rd_a[n_rd] = int'(sif.rd_addr_a); rd_b[n_rd] = int'(sif.rd_addr_b);
      rd_tw[n_rd] = int'(sif.tw_addr); rd_busy[n_rd] = int'(sif.busy);
      n_rd = n_rd + 1;
    end
    if (sif.bf_iact && n_ia < 256) begin
      ia_cyc[n_ia] = cyc; ia_addr[n_ia] = int'(sif.bf_addr); ia_ctrl[n_ia] = int'(sif.bf_ictrl);
      n_ia = n_ia + 1;
    end
    if (sif.wr_en && n_wr < 256) begin
      wr_cyc[n_wr] = cyc; wr_a[n_wr] = int'(sif.wr_addr_a); wr_b[n_wr] = int'(sif.wr_addr_b);
      n_wr = n_wr + 1;
    end
    if (sif.done && n_dn < 16) begin
      dn_cyc[n_dn] = cyc; dn_busy[n_dn] = int'(sif.busy);
      n_dn = n_dn + 1;
    end
  end

  // Property counters for the 1024-point instance
  int big_rd = 0, big_wr = 0, big_dn = 0, big_bad0 = 0, big_bad9 = 0;
  always @(negedge clk) begin
    if (bif.rd_en) begin
      if (big_rd < 512 && int'(bif.tw_addr) != big_rd) big_bad0 = big_bad0 + 1;
      big_rd = big_rd + 1;
    end
    if (bif.wr_en) begin
      if (big_wr >= 9*512 && int'(bif.wr_addr_b) != int'(bif.wr_addr_a) + 1) big_bad9 = big_bad9 + 1;
      big_wr = big_wr + 1;
    end
    if (bif.done) big_dn = big_dn + 1;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", tag, name, act, exp);
  endtask

  function automatic int pack_s();
    return int'({sif.busy, sif.done, sif.rd_en, sif.rd_addr_a, sif.rd_addr_b, sif.tw_addr,
                 sif.bf_iact, sif.bf_ictrl, sif.bf_addr, sif.wr_en, sif.wr_addr_a, sif.wr_addr_b});
  endfunction

  typedef struct {int s; int j; int a; int b; int tw;} vec_t;
  vec_t vt [12];

  task automatic pulse_start_s();
    @(negedge clk); sif.start = 1'b1;
    @(negedge clk); sif.start = 1'b0;
  endtask

  task automatic run_xform(input string tag, input bit extra);
    int br, bi, bw, bd, t, ia_before, wr_before, ec;
    br = n_rd; bi = n_ia; bw = n_wr; bd = n_dn;
    pulse_start_s();
    t = 0;
    while (n_dn == bd && t < 200) begin
      @(negedge clk);
      sif.start = extra && (t == 3 || t == 14 || t == 24);
      t++;
    end
    sif.start = 1'b0;
    chk(tag, "done_within_budget", int'(n_dn != bd), 1);
    repeat (12) @(negedge clk);
    chk(tag, "rd_count", n_rd - br, 12);
    chk(tag, "iact_count", n_ia - bi, 12);
    chk(tag, "wr_count", n_wr - bw, 12);
    chk(tag, "done_count", n_dn - bd, 1);
    for (int k = 0; k < 12; k++) begin
      ec = ((vt[k].s == 2 && vt[k].j == 3) ? 2 : 0) | ((vt[k].j == 0) ? 1 : 0);
      chk(tag, $sformatf("rd_addr_a[%0d]", k), rd_a[br+k], vt[k].a);
      chk(tag, $sformatf("rd_addr_b[%0d]", k), rd_b[br+k], vt[k].b);
      chk(tag, $sformatf("tw_addr[%0d]", k), rd_tw[br+k], vt[k].tw);
      chk(tag, $sformatf("busy_at_rd[%0d]", k), rd_busy[br+k], 1);
      chk(tag, $sformatf("iact_lag[%0d]", k), ia_cyc[bi+k] - rd_cyc[br+k], 1);
      chk(tag, $sformatf("bf_addr[%0d]", k), ia_addr[bi+k], vt[k].j);
      chk(tag, $sformatf("bf_ictrl[%0d]", k), ia_ctrl[bi+k], ec);
      chk(tag, $sformatf("wr_addr_a[%0d]", k), wr_a[bw+k], vt[k].a);
      chk(tag, $sformatf("wr_addr_b[%0d]", k), wr_b[bw+k], vt[k].b);
    end
    for (int s = 1; s < 3; s++) begin
      chk(tag, $sformatf("hazard_stage%0d", s),
          int'(rd_cyc[br+4*s] > wr_cyc[bw+4*s-1]), 1);
      ia_before = 0; wr_before = 0;
      for (int i = bi; i < n_ia; i++) if (ia_cyc[i] < rd_cyc[br+4*s]) ia_before++;
      for (int i = bw; i < n_wr; i++) if (wr_cyc[i] < rd_cyc[br+4*s]) wr_before++;
      chk(tag, $sformatf("outstanding_at_stage%0d", s), ia_before - wr_before, 0);
    end
    chk(tag, "done_after_last_wr", dn_cyc[bd] - wr_cyc[bw+11], 1);
    chk(tag, "busy_at_done", dn_busy[bd], 0);
  endtask

  initial begin
    int br, bw, bd, t;
    vt[0]  = '{0, 0, 0, 4, 0}; vt[1]  = '{0, 1, 1, 5, 1};
    vt[2]  = '{0, 2, 2, 6, 2}; vt[3]  = '{0, 3, 3, 7, 3};
    vt[4]  = '{1, 0, 0, 2, 0}; vt[5]  = '{1, 1, 1, 3, 2};
    vt[6]  = '{1, 2, 4, 6, 0}; vt[7]  = '{1, 3, 5, 7, 2};
    vt[8]  = '{2, 0, 0, 1, 0}; vt[9]  = '{2, 1, 2, 3, 0};
    vt[10] = '{2, 2, 4, 5, 0}; vt[11] = '{2, 3, 6, 7, 0};

    sif.start = 1'b0;
    bif.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset", "outputs_n3", pack_s(), 0);
    chk("reset", "busy_n10", int'(bif.busy | bif.done | bif.rd_en | bif.wr_en | bif.bf_iact), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_xform("first", 1'b0);
    run_xform("start_while_busy", 1'b1);
    run_xform("start_after_done", 1'b0);

    // Abort mid stage 1, then confirm a clean restart
    br = n_rd;
    pulse_start_s();
    t = 0;
    while (n_rd - br < 6 && t < 100) begin @(negedge clk); t++; end
    chk("abort", "reached_stage1", int'(n_rd - br >= 6), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort", "outputs_after_reset", pack_s(), 0);
    rst = 1'b0;
    bw = n_wr; bd = n_dn;
    repeat (15) @(negedge clk);
    chk("abort", "no_wr_while_idle", n_wr - bw, 0);
    chk("abort", "no_done", n_dn - bd, 0);
    chk("abort", "busy_idle", int'(sif.busy), 0);
    run_xform("after_abort", 1'b0);

    // 1024-point transform
    @(negedge clk); bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    t = 0;
    while (big_dn == 0 && t < 8000) begin @(negedge clk); t++; end
    chk("n10", "done_within_budget", int'(big_dn != 0), 1);
    repeat (12) @(negedge clk);
    chk("n10", "rd_count", big_rd, 5120);
    chk("n10", "wr_count", big_wr, 5120);
    chk("n10", "done_count", big_dn, 1);
    chk("n10", "stage0_tw_eq_j_violations", big_bad0, 0);
    chk("n10", "stage9_b_eq_a_plus1_violations", big_bad9, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fft_butterfly_sequencer.md
Name: fft_butterfly_sequencer

Overview:
- Control-side counterpart of the radix-2 DIF butterfly. Drives the butterfly's issue side (iact/ictrl/input address) and consumes its return side (oact/octrl/output address).
- Runs an in-place 2^FFT_N-point DIF FFT over one data RAM, stage by stage. Generates RAM read addresses, twiddle ROM addresses and butterfly issue strobes. Converts returned butterfly indices into RAM write-back addresses.
- Sits between the FFT top-level start/done control, the data RAM, the twiddle ROM and the butterfly.

Parameters:
- FFT_N, 10, log2 of FFT size; FFT_N-1 bits index a butterfly within a stage.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a transform when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse when the last write-back has completed
- rd_en  out  1  data RAM read strobe (RAM read latency is 1 cycle)
- rd_addr_a  out  FFT_N  RAM address of butterfly input A
- rd_addr_b  out  FFT_N  RAM address of butterfly input B
- tw_addr  out  FFT_N-1  twiddle ROM index (ROM latency 1 cycle)
- bf_iact  out  1  butterfly input valid
- bf_ictrl  out  2  bit0 = first butterfly of stage; bit1 = last butterfly of final stage
- bf_addr  out  FFT_N-1  butterfly index j travelling with the data
- bf_oact  in  1  butterfly result valid
- bf_octrl  in  2  returned ctrl
- bf_out_addr  in  FFT_N-1  returned index j
- wr_en  out  1  RAM write strobe (A and B results both written)
- wr_addr_a  out  FFT_N  write address for out_A
- wr_addr_b  out  FFT_N  write address for out_B

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Stage, index and outstanding counters cleared. Reset mid-transform aborts it; no done pulse.
- FSM states: IDLE -> ISSUE on start. ISSUE -> DRAIN after issuing j = 2^(FFT_N-1)-1. DRAIN -> ISSUE (stage+1) when outstanding count = 0 and stage < FFT_N-1. DRAIN -> DONE when outstanding count = 0 and stage = FFT_N-1. DONE -> IDLE after one cycle.
- start is ignored while busy=1.
- Address maths for stage s (0..FFT_N-1): span = 2^(FFT_N-1-s), g = j >> (FFT_N-1-s), k = j & (span-1).
  - addr_a = g*2*span + k
  - addr_b = addr_a + span
  - tw_addr = k << s, truncated to FFT_N-1 bits
- ISSUE: one butterfly per cycle. rd_en=1 with rd_addr_a/b and tw_addr registered from the current j. j increments each cycle.
- bf_iact, bf_addr and bf_ictrl are asserted exactly 1 cycle after the matching rd_en, aligned with RAM/ROM data.
- bf_ictrl bit0=1 for j=0. bit1=1 only for j = max on stage FFT_N-1.
- Write-back: on each cycle with bf_oact=1, the next cycle drives wr_en=1. wr_addr_a/b are computed from bf_out_addr with the same formula using the current stage register. The stage is guaranteed stable because the next stage is not issued until drain completes.
- Outstanding counter (FFT_N+1 bits):
  - +1 on each bf_iact.
  - -1 on each wr_en.
  - Both in the same cycle: unchanged.
  - Never underflows; a wr_en with count 0 is an assertion failure.
- Hazard rule: the first rd_en of stage s+1 occurs no earlier than the cycle after the final wr_en of stage s.
- done: pulses 1 cycle after the final wr_en of the final stage. busy falls in the same cycle.
- bf_oact while IDLE is ignored: no wr_en, counter unchanged.
- Throughput: fully pipelined within a stage, no bubbles. Stage gap = butterfly latency + 3 cycles.

Test Plan:
- FFT_N=3, 6-cycle butterfly model, one start -> stage0 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3; stage1 (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2; stage2 (0,1),(2,3),(4,5),(6,7) with tw 0. Writes hit the same pairs. Exactly 12 wr_en, then done=1 once.
- Alignment -> every bf_iact is exactly 1 cycle after its rd_en. bf_ictrl=01 only on each stage's j=0. bf_ictrl=1x only on stage2 j=3.
- Hazard: for each stage, the cycle of the first rd_en is greater than the cycle of the previous stage's last wr_en. The outstanding counter reads 0 at every stage boundary.
- start pulsed again while busy -> ignored; still exactly 12 writes and one done. A start after done begins a new transform with the stage0 pattern.
- reset asserted mid stage1 -> next cycle all outputs 0, busy=0, no done. A subsequent start gives the full correct sequence.
- FFT_N=10 -> 5120 wr_en in total. In stage 9, wr_addr_b = wr_addr_a + 1 for every write. In stage 0, tw_addr = j.
